// File: rtl/breath_duty_sequencer.sv
// breath_duty_sequencer: owns the PWM period counter and the breathing duty profile
// (ramp up, hold high, ramp down, hold low). Steps and hold lengths are loaded through a
// one-deep shadow register and only reach the active set on a period boundary.
`timescale 1ns/1ps
module breath_duty_sequencer #(
  parameter int unsigned PERIOD_MAX  = 50000,
  parameter int unsigned DUTY_W      = 16,
  parameter int unsigned UP_STEP_RST = 50,
  parameter int unsigned DN_STEP_RST = 25,
  parameter int unsigned HOLD_W      = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DUTY_W-1:0] cfg_up_step,
  input  logic [DUTY_W-1:0] cfg_dn_step,
  input  logic [HOLD_W-1:0] cfg_hold_hi,
  input  logic [HOLD_W-1:0] cfg_hold_lo,
  output logic [DUTY_W-1:0] period_cnt,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              period_end,
  output logic [2:0]        phase
);

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_RAMP_UP = 3'd1,
    PH_HOLD_HI = 3'd2,
    PH_RAMP_DN = 3'd3,
    PH_HOLD_LO = 3'd4
  } phase_t;

  localparam logic [DUTY_W-1:0] PMAX     = DUTY_W'(PERIOD_MAX);
  localparam logic [DUTY_W-1:0] ONE_STEP = DUTY_W'(1);

  phase_t              state, state_nxt;
  logic [DUTY_W-1:0]   duty_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [DUTY_W-1:0]   up_act, dn_act, up_shd, dn_shd;
  logic [HOLD_W-1:0]   hold_hi_act, hold_lo_act, hold_hi_shd, hold_lo_shd;
  logic                shd_full;
  logic                cfg_fire, apply_shd;
  logic [DUTY_W-1:0]   up_use, dn_use, up_eff, dn_eff;
  logic [HOLD_W-1:0]   hold_hi_use, hold_lo_use;
  logic [DUTY_W:0]     up_sum;
  logic [HOLD_W:0]     hold_inc;

  assign phase      = state;
  assign period_end = (period_cnt == PMAX) && (state != PH_IDLE);
  assign cfg_ready  = ~shd_full;
  assign cfg_fire   = cfg_valid && cfg_ready;
  // A pending shadow word is consumed on a period boundary, or straight away when idle.
  assign apply_shd  = shd_full && (period_end || (state == PH_IDLE));

  // The update on the boundary that consumes the shadow already uses the new values.
  assign up_use      = apply_shd ? up_shd      : up_act;
  assign dn_use      = apply_shd ? dn_shd      : dn_act;
  assign hold_hi_use = apply_shd ? hold_hi_shd : hold_hi_act;
  assign hold_lo_use = apply_shd ? hold_lo_shd : hold_lo_act;

  // A zero step would freeze the profile, so it behaves as a step of one.
  assign up_eff   = (up_use == '0) ? ONE_STEP : up_use;
  assign dn_eff   = (dn_use == '0) ? ONE_STEP : dn_use;
  assign up_sum   = {1'b0, duty_cycle} + {1'b0, up_eff};
  assign hold_inc = {1'b0, hold_cnt} + {{HOLD_W{1'b0}}, 1'b1};

  // Period counter: parked at zero while idle, otherwise wraps from PERIOD_MAX to zero.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      period_cnt <= '0;
    end else if ((state == PH_IDLE) || (period_cnt == PMAX)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + ONE_STEP;
    end
  end

  // Config path: handshake into the shadow, then move shadow to active on a boundary.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shd_full    <= 1'b0;
      up_act      <= DUTY_W'(UP_STEP_RST);
      dn_act      <= DUTY_W'(DN_STEP_RST);
      hold_hi_act <= '0;
      hold_lo_act <= '0;
      up_shd      <= '0;
      dn_shd      <= '0;
      hold_hi_shd <= '0;
      hold_lo_shd <= '0;
    end else begin
      if (apply_shd) begin
        up_act      <= up_shd;
        dn_act      <= dn_shd;
        hold_hi_act <= hold_hi_shd;
        hold_lo_act <= hold_lo_shd;
        shd_full    <= 1'b0;
      end
      if (cfg_fire) begin
        up_shd      <= cfg_up_step;
        dn_shd      <= cfg_dn_step;
        hold_hi_shd <= cfg_hold_hi;
        hold_lo_shd <= cfg_hold_lo;
        shd_full    <= 1'b1;
      end
    end
  end

  // Profile state register: phase, current duty and hold-period count.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= PH_IDLE;
      duty_cycle <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      duty_cycle <= duty_nxt;
      hold_cnt   <= hold_cnt_nxt;
    end
  end

  // Profile next-state: only period boundaries move the duty, except leaving idle.
  always_comb begin
    state_nxt    = state;
    duty_nxt     = duty_cycle;
    hold_cnt_nxt = hold_cnt;
    if (state == PH_IDLE) begin
      hold_cnt_nxt = '0;
      if (enable) begin
        state_nxt = PH_RAMP_UP;
      end
    end else if (period_end) begin
      if (!enable) begin
        hold_cnt_nxt = '0;
        if (duty_cycle <= dn_eff) begin
          duty_nxt  = '0;
          state_nxt = PH_IDLE;
        end else begin
          duty_nxt  = duty_cycle - dn_eff;
          state_nxt = PH_RAMP_DN;
        end
      end else begin
        case (state)
          PH_RAMP_UP: begin
            if (up_sum >= {1'b0, PMAX}) begin
              duty_nxt     = PMAX;
              hold_cnt_nxt = '0;
              state_nxt    = (hold_hi_use == '0) ? PH_RAMP_DN : PH_HOLD_HI;
            end else begin
              duty_nxt = up_sum[DUTY_W-1:0];
            end
          end
          PH_HOLD_HI: begin
            if (hold_inc >= {1'b0, hold_hi_use}) begin
              hold_cnt_nxt = '0;
              state_nxt    = PH_RAMP_DN;
            end else begin
              hold_cnt_nxt = hold_inc[HOLD_W-1:0];
            end
          end
          PH_RAMP_DN: begin
            if (duty_cycle <= dn_eff) begin
              duty_nxt     = '0;
              hold_cnt_nxt = '0;
              state_nxt    = (hold_lo_use == '0) ? PH_RAMP_UP : PH_HOLD_LO;
            end else begin
              duty_nxt = duty_cycle - dn_eff;
            end
          end
          PH_HOLD_LO: begin
            if (hold_inc >= {1'b0, hold_lo_use}) begin
              hold_cnt_nxt = '0;
              state_nxt    = PH_RAMP_UP;
            end else begin
              hold_cnt_nxt = hold_inc[HOLD_W-1:0];
            end
          end
          default: begin
            state_nxt = PH_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_breath_duty_sequencer.sv
// tb_breath_duty_sequencer: period-level reference model feeding an expectation queue;
// a monitor pops one entry at every period_end and compares duty, phase and cfg_ready.
`timescale 1ns/1ps
module tb_breath_duty_sequencer;

  localparam int PM      = 39;
  localparam int UP_RST  = 7;
  localparam int DN_RST  = 5;
  localparam int IDLE    = 0;
  localparam int RAMP_UP = 1;
  localparam int HOLD_HI = 2;
  localparam int RAMP_DN = 3;
  localparam int HOLD_LO = 4;

  logic        sys_clk;
  logic        sys_rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_up_step;
  logic [15:0] cfg_dn_step;
  logic [7:0]  cfg_hold_hi;
  logic [7:0]  cfg_hold_lo;
  logic [15:0] period_cnt;
  logic [15:0] duty_cycle;
  logic        period_end;
  logic [2:0]  phase;

  typedef struct {
    int duty;
    int phase;
    int ready;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;

  int m_phase, m_duty, m_hcnt, m_up, m_dn, m_hhi, m_hlo;
  bit s_full;
  int s_up, s_dn, s_hhi, s_hlo;

  breath_duty_sequencer #(
    .PERIOD_MAX (PM),
    .DUTY_W     (16),
    .UP_STEP_RST(UP_RST),
    .DN_STEP_RST(DN_RST),
    .HOLD_W     (8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_up_step(cfg_up_step),
    .cfg_dn_step(cfg_dn_step),
    .cfg_hold_hi(cfg_hold_hi),
    .cfg_hold_lo(cfg_hold_lo),
    .period_cnt (period_cnt),
    .duty_cycle (duty_cycle),
    .period_end (period_end),
    .phase      (phase)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model of the profile, one step per PWM period.
  task automatic modelReset();
    m_phase = IDLE; m_duty = 0; m_hcnt = 0;
    m_up = UP_RST; m_dn = DN_RST; m_hhi = 0; m_hlo = 0;
    s_full = 0; s_up = 0; s_dn = 0; s_hhi = 0; s_hlo = 0;
  endtask

  task automatic modelLoad(input int up, input int dn, input int hhi, input int hlo);
    s_up = up; s_dn = dn; s_hhi = hhi; s_hlo = hlo; s_full = 1;
  endtask

  task automatic modelPeriodEnd(input bit en);
    int up, dn;
    if (s_full) begin
      m_up = s_up; m_dn = s_dn; m_hhi = s_hhi; m_hlo = s_hlo; s_full = 0;
    end
    up = (m_up == 0) ? 1 : m_up;
    dn = (m_dn == 0) ? 1 : m_dn;
    if (!en) begin
      m_hcnt  = 0;
      m_duty  = (m_duty <= dn) ? 0 : m_duty - dn;
      m_phase = (m_duty == 0) ? IDLE : RAMP_DN;
    end else begin
      case (m_phase)
        RAMP_UP: begin
          if (m_duty + up >= PM) begin
            m_duty = PM; m_hcnt = 0;
            m_phase = (m_hhi == 0) ? RAMP_DN : HOLD_HI;
          end else m_duty = m_duty + up;
        end
        HOLD_HI: begin
          m_hcnt++;
          if (m_hcnt >= m_hhi) begin m_hcnt = 0; m_phase = RAMP_DN; end
        end
        RAMP_DN: begin
          if (m_duty <= dn) begin
            m_duty = 0; m_hcnt = 0;
            m_phase = (m_hlo == 0) ? RAMP_UP : HOLD_LO;
          end else m_duty = m_duty - dn;
        end
        HOLD_LO: begin
          m_hcnt++;
          if (m_hcnt >= m_hlo) begin m_hcnt = 0; m_phase = RAMP_UP; end
        end
        default: m_phase = IDLE;
      endcase
    end
  endtask

  task automatic modelIdleEdge(input bit fire, input int up, input int dn, input int hhi,
                               input int hlo, input bit en);
    if (s_full) begin
      m_up = s_up; m_dn = s_dn; m_hhi = s_hhi; m_hlo = s_hlo; s_full = 0;
    end
    if (fire) modelLoad(up, dn, hhi, hlo);
    if (en) begin m_phase = RAMP_UP; m_hcnt = 0; end
  endtask

  // Drives one full PWM period starting at the negedge of its first cycle.
  // cfg_at < 0 means no config word this period; cfg_at == PM lands on period_end.
  task automatic applyStimulus(input int cfg_at, input int up, input int dn, input int hhi,
                               input int hlo, input int en_at, input bit en_val);
    exp_t e;
    int   ca;
    ca = s_full ? -1 : cfg_at;
    e.duty  = m_duty;
    e.phase = m_phase;
    e.ready = (s_full || (ca >= 0 && ca < PM)) ? 0 : 1;
    exp_q.push_back(e);
    for (int i = 0; i <= PM; i++) begin
      if (i == 0) begin
        checkOutput("period_start_cnt", 32'(period_cnt), 0);
        checkOutput("period_start_ready", 32'(cfg_ready), s_full ? 0 : 1);
      end
      if (i == en_at) enable = en_val;
      if (i == ca) begin
        cfg_valid   = 1'b1;
        cfg_up_step = up[15:0];
        cfg_dn_step = dn[15:0];
        cfg_hold_hi = hhi[7:0];
        cfg_hold_lo = hlo[7:0];
        if (i < PM) modelLoad(up, dn, hhi, hlo);
      end else begin
        cfg_valid = 1'b0;
      end
      if (i < PM) @(negedge sys_clk);
    end
    checkOutput("period_end_timing", 32'(period_end), 1);
    modelPeriodEnd(enable);
    if (ca == PM) modelLoad(up, dn, hhi, hlo);
    @(negedge sys_clk);
    cfg_valid = 1'b0;
  endtask

  // Spends n cycles in IDLE (optionally loading config), then raises enable.
  task automatic runIdle(input int n, input bit do_cfg, input int up, input int dn,
                         input int hhi, input int hlo);
    bit fire;
    for (int i = 0; i < n; i++) begin
      checkOutput("idle_cnt", 32'(period_cnt), 0);
      checkOutput("idle_period_end", 32'(period_end), 0);
      checkOutput("idle_phase", 32'(phase), IDLE);
      checkOutput("idle_duty", 32'(duty_cycle), 0);
      checkOutput("idle_ready", 32'(cfg_ready), s_full ? 0 : 1);
      enable = 1'b0;
      fire = do_cfg && (i == 0) && !s_full;
      cfg_valid = fire;
      if (fire) begin
        cfg_up_step = up[15:0]; cfg_dn_step = dn[15:0];
        cfg_hold_hi = hhi[7:0]; cfg_hold_lo = hlo[7:0];
      end
      modelIdleEdge(fire, up, dn, hhi, hlo, 1'b0);
      @(negedge sys_clk);
    end
    cfg_valid = 1'b0;
    enable    = 1'b1;
    modelIdleEdge(1'b0, 0, 0, 0, 0, 1'b1);
    @(negedge sys_clk);
  endtask

  function automatic int pickStep();
    int sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0: return 0;
      1: return 65535;
      2: return PM;
      default: return int'($urandom_range(1, 20));
    endcase
  endfunction

  // Monitor: each period_end presents one period's worth of output to the scoreboard.
  always @(negedge sys_clk) begin
    if (!sys_rst && period_end === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_period_end", 32'(exp_q.size()), 1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_duty", 32'(duty_cycle), e.duty);
        checkOutput("sb_phase", 32'(phase), e.phase);
        checkOutput("sb_cfg_ready", 32'(cfg_ready), e.ready);
      end
    end
  end

  initial begin
    int  guard;
    bit  cur_en;
    int  ca, en_at;
    tests_run = 0; tests_failed = 0;
    sys_rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_up_step = '0; cfg_dn_step = '0; cfg_hold_hi = '0; cfg_hold_lo = '0;
    modelReset();
    repeat (3) @(negedge sys_clk);
    checkOutput("rst_cnt", 32'(period_cnt), 0);
    checkOutput("rst_duty", 32'(duty_cycle), 0);
    checkOutput("rst_phase", 32'(phase), IDLE);
    checkOutput("rst_period_end", 32'(period_end), 0);
    checkOutput("rst_ready", 32'(cfg_ready), 1);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Default steps: ramp, clamp, ramp down, repeat.
    runIdle(3, 1'b0, 0, 0, 0, 0);
    repeat (25) applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);

    // Large steps with holds, both ends clamp.
    applyStimulus(5, 30, 30, 3, 2, 0, 1'b1);
    repeat (16) applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);

    // Config landing on the period_end cycle.
    applyStimulus(PM, 3, 4, 0, 0, 0, 1'b1);
    repeat (4) applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);

    // Fade out while ramping up, then settle in IDLE.
    guard = 0;
    while (guard < 40 && !(m_phase == RAMP_UP && m_duty > 10)) begin
      applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);
      guard++;
    end
    applyStimulus(-1, 0, 0, 0, 0, 3, 1'b0);
    guard = 0;
    while (guard < 50 && m_phase != IDLE) begin
      applyStimulus(-1, 0, 0, 0, 0, 0, 1'b0);
      guard++;
    end
    checkOutput("fade_reached_idle", 32'(m_phase == IDLE), 1);

    // Zero up-step loaded while idle, then saturating steps.
    runIdle(4, 1'b1, 0, 6, 1, 1);
    repeat (8) applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);
    applyStimulus(10, 65535, 65535, 0, 0, 0, 1'b1);
    repeat (6) applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);

    // Randomized mix of config words, boundary-aligned transfers and enable toggles.
    cur_en = 1'b1;
    repeat (200) begin
      if (m_phase == IDLE) begin
        cur_en = 1'b1;
        runIdle(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), pickStep(), pickStep(),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        if (cur_en && $urandom_range(0, 9) == 0) cur_en = 1'b0;
        else if (!cur_en && $urandom_range(0, 2) == 0) cur_en = 1'b1;
        if ($urandom_range(0, 3) == 0)
          ca = ($urandom_range(0, 1) == 1) ? PM : int'($urandom_range(0, PM - 1));
        else
          ca = -1;
        en_at = int'($urandom_range(0, PM));
        applyStimulus(ca, pickStep(), pickStep(), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), en_at, cur_en);
      end
    end

    // Reach RAMP_DN with fast steps, park a shadow word, then reset asynchronously.
    if (m_phase == IDLE) runIdle(2, 1'b0, 0, 0, 0, 0);
    applyStimulus(0, 7, 5, 0, 0, 0, 1'b1);
    guard = 0;
    while (guard < 100 && !(m_phase == RAMP_DN && !s_full && m_duty > 0)) begin
      if (m_phase == IDLE) runIdle(2, 1'b0, 0, 0, 0, 0);
      else applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);
      guard++;
    end
    cfg_valid = 1'b1; cfg_up_step = 16'd11; cfg_dn_step = 16'd13;
    cfg_hold_hi = 8'd2; cfg_hold_lo = 8'd2;
    @(negedge sys_clk);
    cfg_valid = 1'b0;
    checkOutput("pending_ready_low", 32'(cfg_ready), 0);
    #2 sys_rst = 1'b1;
    #1;
    checkOutput("async_rst_cnt", 32'(period_cnt), 0);
    checkOutput("async_rst_duty", 32'(duty_cycle), 0);
    checkOutput("async_rst_phase", 32'(phase), IDLE);
    checkOutput("async_rst_period_end", 32'(period_end), 0);
    checkOutput("async_rst_ready", 32'(cfg_ready), 1);
    @(negedge sys_clk);
    enable  = 1'b0;
    sys_rst = 1'b0;
    modelReset();
    exp_q.delete();
    runIdle(2, 1'b0, 0, 0, 0, 0);
    repeat (10) applyStimulus(-1, 0, 0, 0, 0, 0, 1'b1);

    checkOutput("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
